// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic family (adder/subtractor).
// State encoding and counter-width helper.
package arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fs1bit.sv
// Combinational 1-bit full subtractor: a - b - bin -> d with borrow-out.
module fs1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial_nbit.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock through a single
// full-subtractor cell. start/busy/done handshake; results held until next completion.
module sub_serial_nbit
  import arith_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  state_t             state;
  logic [N-1:0]       sa, sb, res;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic               d_bit, br_nxt;
  logic [N-1:0]       res_nxt;

  fs1bit u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_nxt)
  );

  // Result fills from the MSB so after N shifts bit 0 lands in res[0].
  assign res_nxt = {d_bit, res[N-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res <= res_nxt;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            diff  <= res_nxt;
            bout  <= br_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_nbit.sv
// Randomized self-checking bench for sub_serial_nbit against an arithmetic model.
module tb_sub_serial_nbit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [N-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] held_diff;
  logic         held_bout;

  sub_serial_nbit #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi,
                       output logic [N-1:0] d, output logic bo);
    d  = x - y - N'(bi);
    bo = ({1'b0, x} < ({1'b0, y} + (N+1)'(bi)));
  endtask

  // Sample #1 after each rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One operation; optional re-pulse of start at a given RUN cycle.
  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi,
                       input int repulse_at);
    logic [N-1:0] ed;
    logic         eb;
    int           cyc;
    model(x, y, bi, ed, eb);
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
    chk("busy_on_accept", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        chk("diff_held", diff, held_diff);
        chk("bout_held", 32'(held_bout), 32'(bout));
      end
      if (repulse_at > 0 && cyc == repulse_at) begin
        start = 1'b1; a = 100; b = 1; bin = 1'b0;
      end else if (repulse_at > 0 && cyc == repulse_at + 1) begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'(N));
    chk("diff", diff, ed);
    chk("bout", 32'(bout), 32'(eb));
    chk("busy_at_done", 32'(busy), 32'd0);
    held_diff = ed; held_bout = eb;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, extra;
    logic [N-1:0] ed;
    logic         eb;
    logic [N-1:0] ra, rb;
    logic         rbi;

    rst = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    held_diff = '0; held_bout = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy || diff != 0) extra++;
    end
    chk("quiet_idle", 32'(extra), 32'd0);

    do_op(32'd10, 32'd3, 1'b0, 0);
    do_op(32'd0, 32'd1, 1'b0, 0);
    chk("const_ffff", diff, 32'hFFFF_FFFF);
    do_op(32'd5, 32'd5, 1'b1, 0);
    do_op(32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    chk("const_fffe", diff, 32'hFFFF_FFFE);

    // start re-pulsed mid-run must be ignored
    do_op(32'd50, 32'd20, 1'b0, 10);
    chk("repulse_diff", diff, 32'd30);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) extra++;
    end
    chk("repulse_no_extra_done", 32'(extra), 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    a = 32'd9; b = 32'd4; bin = 1'b0; start = 1'b1;
    cyc = 0;
    tick();
    while (!done && cyc < 100) begin tick(); cyc++; end
    chk("b2b_first_diff", diff, 32'd5);
    chk("b2b_first_bout", 32'(bout), 32'd0);
    a = 32'd4; b = 32'd9;
    cyc = 0;
    tick(); cyc++;
    while (!done && cyc < 100) begin tick(); cyc++; end
    start = 1'b0;
    chk("b2b_spacing", 32'(cyc), 32'(N + 1));
    chk("b2b_second_diff", diff, 32'hFFFF_FFFB);
    chk("b2b_second_bout", 32'(bout), 32'd1);
    held_diff = 32'hFFFF_FFFB; held_bout = 1'b1;
    tick();
    chk("b2b_idle_after", 32'(busy), 32'd0);

    // Reset in the middle of a run
    @(negedge clk);
    a = 32'd123; b = 32'd45; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", diff, 32'd0);
    chk("midrst_bout", 32'(bout), 32'd0);
    held_diff = '0; held_bout = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) extra++;
    end
    chk("midrst_no_done", 32'(extra), 32'd0);
    do_op(32'd7, 32'd2, 1'b0, 0);
    chk("after_rst_diff", diff, 32'd5);

    // Randomized operands, biased to hit equal operands and extremes
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rb  = (i % 6 == 0) ? ra : ((i % 6 == 1) ? 32'hFFFF_FFFF : $urandom);
      rbi = 1'($urandom);
      do_op(ra, rb, rbi, 0);
    end
    model(32'd1, 32'd2, 1'b1, ed, eb);
    do_op(32'd1, 32'd2, 1'b1, 0);
    chk("model_small_bout", 32'(bout), 32'(eb));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
